// File: rtl/filter_sample_tx.sv
// filter_sample_tx
//   Queues 33-bit filtered samples in a small FIFO and sends each one to the
//   host as a 5-byte 8N1 UART frame: {7'b0, s[32]}, s[31:24], s[23:16],
//   s[15:8], s[7:0], every byte LSB first.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | line high; pop FIFO head into the shift register if any
//   START | start bit (0) for CLKS_PER_BIT cycles
//   DATA  | 8 data bits, LSB of shift register, shift after each bit
//   STOP  | stop bit (1); next byte or back to IDLE after byte 4
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   outSignal  sample word (bit 32 status flag, [31:0] IEEE-754 single)
//   dataReady  sample valid, rising-edge qualified
//   txd        UART output, idles high
//   busy       FSM not IDLE or FIFO non-empty
//   overflow   sticky, a sample was dropped on a full FIFO
//   fifoCount  occupied FIFO entries
module filter_sample_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [32:0]      outSignal,
  input  logic             dataReady,
  output logic             txd,
  output logic             busy,
  output logic             overflow,
  output logic [FIFO_AW:0] fifoCount
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [2:0]           byte_idx_q, byte_idx_d;
  logic [39:0]          shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 dreq_q;
  logic [32:0]          mem_q [DEPTH];

  logic                 push_req, push_ok, pop;
  logic                 fifo_full, fifo_empty, bit_end;
  logic [32:0]          head;

  // FIFO control. A pop on the same edge frees a slot, so a push onto a
  // full FIFO is accepted when the FSM is popping.
  always_comb begin
    push_req   = dataReady & ~dreq_q;
    fifo_full  = (count_q == (FIFO_AW+1)'(DEPTH));
    fifo_empty = (count_q == '0);
    pop        = (state_q == IDLE) && !fifo_empty;
    push_ok    = push_req && (!fifo_full || pop);
    head       = mem_q[rd_ptr_q];

    wr_ptr_d = push_ok ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + (FIFO_AW+1)'(1);
    else if (!push_ok && pop) count_d = count_q - (FIFO_AW+1)'(1);
    ovf_d = ovf_q | (push_req & fifo_full & ~pop);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    bit_end    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pop) begin
          // Byte order on the wire is low end of the register first.
          shift_d    = {head[7:0], head[15:8], head[23:16], head[31:24],
                        7'b0, head[32]};
          byte_idx_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (byte_idx_q < 3'd4) begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // txd is registered from the next state so it changes cleanly with it.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      dreq_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      dreq_q     <= dataReady;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= outSignal;
  end

  assign txd       = txd_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign overflow  = ovf_q;
  assign fifoCount = count_q;

endmodule

// File: tb/tb_filter_sample_tx.sv
module tb_filter_sample_tx;

  logic        clk;
  logic        rst;
  logic [32:0] outSignal;
  logic        dataReady;
  logic        txd;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifoCount;

  int total = 0;
  int bad   = 0;

  logic [7:0]  rx_q [$];
  logic [32:0] bank [6];

  filter_sample_tx #(.CLKS_PER_BIT(4), .FIFO_AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .outSignal (outSignal),
    .dataReady (dataReady),
    .txd       (txd),
    .busy      (busy),
    .overflow  (overflow),
    .fifoCount (fifoCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // advance to 1 time unit after the n-th next rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] frame_byte(input logic [32:0] v, input int i);
    case (i)
      0:       frame_byte = {7'b0, v[32]};
      1:       frame_byte = v[31:24];
      2:       frame_byte = v[23:16];
      3:       frame_byte = v[15:8];
      default: frame_byte = v[7:0];
    endcase
  endfunction

  task automatic chk_frame(input string tag, input logic [32:0] v);
    for (int i = 0; i < 5; i++) begin
      logic [8:0] got;
      if (rx_q.size() > 0) got = {1'b0, rx_q.pop_front()};
      else                 got = 9'h1ff;
      chk($sformatf("%s_b%0d", tag, i), 64'(got), 64'({1'b0, frame_byte(v, i)}));
    end
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      step(1);
      n++;
    end
    chk({tag, "_idle"}, 64'(busy), 64'(0));
    step(3);
  endtask

  task automatic pulse(input logic [32:0] v);
    outSignal = v;
    dataReady = 1'b1;
    step(1);
    dataReady = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(3);
    rst = 1'b1;
    step(2);
  endtask

  // UART receiver: samples the middle of each 4-cycle bit.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst === 1'b1 && txd === 1'b0) begin
        logic [7:0] b;
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(posedge clk);
          #2;
          b[i] = txd;
        end
        repeat (4) @(posedge clk);
        #2;
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mx;
    bank[0] = 33'h1_11223344;
    bank[1] = 33'h0_55667788;
    bank[2] = 33'h1_99aabbcc;
    bank[3] = 33'h0_ddeeff00;
    bank[4] = 33'h1_0badf00d;
    bank[5] = 33'h0_deadbeef;

    rst       = 1'b0;
    dataReady = 1'b0;
    outSignal = '0;

    // reset values
    step(3);
    chk("rst_txd",   64'(txd),       64'(1));
    chk("rst_busy",  64'(busy),      64'(0));
    chk("rst_ovf",   64'(overflow),  64'(0));
    chk("rst_count", 64'(fifoCount), 64'(0));
    rst = 1'b1;
    step(3);

    // single frame, capture/start latency and frame length
    outSignal = 33'h0_4141669e;
    dataReady = 1'b1;
    step(1);
    dataReady = 1'b0;
    chk("single_cnt1",  64'(fifoCount), 64'(1));
    chk("single_txd_k", 64'(txd),       64'(1));
    step(1);
    chk("single_start", 64'(txd),       64'(0));
    chk("single_busy",  64'(busy),      64'(1));
    chk("single_cnt0",  64'(fifoCount), 64'(0));
    step(199);
    chk("single_busy199", 64'(busy), 64'(1));
    step(1);
    chk("single_busy200", 64'(busy), 64'(0));
    chk("single_txd_end", 64'(txd),  64'(1));
    step(3);
    chk_frame("single", 33'h0_4141669e);
    chk("single_nbytes", 64'(rx_q.size()), 64'(0));

    // long dataReady: one sample only
    outSignal = 33'h1_bf83c6e0;
    dataReady = 1'b1;
    mx = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (int'(fifoCount) > mx) mx = int'(fifoCount);
    end
    dataReady = 1'b0;
    for (int i = 0; i < 300 && busy; i++) begin
      step(1);
      if (int'(fifoCount) > mx) mx = int'(fifoCount);
    end
    wait_idle("long", 10);
    chk("long_maxcnt", 64'(mx), 64'(1));
    chk_frame("long", 33'h1_bf83c6e0);
    chk("long_nbytes", 64'(rx_q.size()), 64'(0));

    // burst of 6 with overflow
    for (int i = 0; i < 6; i++) begin
      pulse(bank[i]);
      step(1);
    end
    chk("burst_cnt", 64'(fifoCount), 64'(4));
    chk("burst_ovf", 64'(overflow),  64'(1));
    wait_idle("burst", 1300);
    chk("burst_ovf_sticky", 64'(overflow), 64'(1));
    for (int i = 0; i < 5; i++) chk_frame($sformatf("burst%0d", i), bank[i]);
    chk("burst_nbytes", 64'(rx_q.size()), 64'(0));

    // push and pop on the same edge while full
    do_reset();
    chk("sim_ovf_clr", 64'(overflow), 64'(0));
    pulse(bank[5]);             // now 1 unit after capture edge kA
    step(1);                    // kA+1: popped, frame A starts
    for (int i = 0; i < 4; i++) begin
      pulse(bank[i]);
      step(1);
    end                         // kA+9
    chk("sim_full", 64'(fifoCount), 64'(4));
    step(192);                  // kA+201: FSM back in IDLE
    chk("sim_idle_txd", 64'(txd), 64'(1));
    pulse(33'h0_c2f60000);      // sampled on the popping edge
    chk("sim_cnt",   64'(fifoCount), 64'(4));
    chk("sim_ovf",   64'(overflow),  64'(0));
    chk("sim_start", 64'(txd),       64'(0));
    wait_idle("sim", 1300);
    chk_frame("simA", bank[5]);
    for (int i = 0; i < 4; i++) chk_frame($sformatf("sim%0d", i), bank[i]);
    chk_frame("simF", 33'h0_c2f60000);
    chk("sim_nbytes", 64'(rx_q.size()), 64'(0));

    // reset mid-frame during a data bit of byte 2
    pulse(bank[0]);             // capture edge k, pop at k+1
    step(1);                    // k+1
    pulse(bank[1]);             // queued behind the frame in flight
    step(88);                   // k+90: byte 2 data bits
    chk("mid_cnt_pre", 64'(fifoCount), 64'(1));
    rst = 1'b0;
    #1;
    chk("mid_txd",   64'(txd),       64'(1));
    chk("mid_count", 64'(fifoCount), 64'(0));
    chk("mid_busy",  64'(busy),      64'(0));
    step(2);
    rst = 1'b1;
    step(50);
    chk("mid_quiet_txd",  64'(txd),  64'(1));
    chk("mid_quiet_busy", 64'(busy), 64'(0));
    rx_q.delete();
    pulse(33'h1_c0490fdb);
    wait_idle("mid", 300);
    chk_frame("mid_new", 33'h1_c0490fdb);
    chk("mid_nbytes", 64'(rx_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
